// File: rtl/axi_burst_master.sv
// Single-outstanding AXI burst initiator: one read or write command becomes one INCR burst.
// Optional build macro AXI_MASTER_4K_CHECK_EN rejects commands whose burst crosses a 4KB page.
module axi_burst_master #(
  parameter int IDWID = 4,
  parameter int DWID  = 64,
  parameter int WSTRB = DWID / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  // command
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_addr,
  input  logic [7:0]       cmd_len,
  input  logic [IDWID-1:0] cmd_id,
  // local write stream
  input  logic [DWID-1:0]  wr_data,
  input  logic [WSTRB-1:0] wr_strb,
  input  logic             wr_valid,
  output logic             wr_ready,
  // local read stream
  output logic [DWID-1:0]  rd_data,
  output logic             rd_last,
  output logic             rd_valid,
  input  logic             rd_ready,
  // completion
  output logic             done_valid,
  output logic             done_write,
  output logic [IDWID-1:0] done_id,
  output logic [1:0]       done_resp,
  output logic [1:0]       done_err,
  // AXI read address / data
  output logic [IDWID-1:0] arid,
  output logic [31:0]      araddr,
  output logic [7:0]       arlen,
  output logic [1:0]       arburst,
  output logic             arvalid,
  input  logic             arready,
  input  logic [IDWID-1:0] rid,
  input  logic [DWID-1:0]  rdata,
  input  logic [1:0]       rresp,
  input  logic             rlast,
  input  logic             rvalid,
  output logic             rready,
  // AXI write address / data / response
  output logic [IDWID-1:0] awid,
  output logic [31:0]      awaddr,
  output logic [7:0]       awlen,
  output logic [1:0]       awburst,
  output logic             awvalid,
  input  logic             awready,
  output logic [DWID-1:0]  wdata,
  output logic [WSTRB-1:0] wstrb,
  output logic             wlast,
  output logic             wvalid,
  input  logic             wready,
  input  logic [IDWID-1:0] bid,
  input  logic [1:0]       bresp,
  input  logic             bvalid,
  output logic             bready
);

  typedef enum logic [2:0] {S_IDLE, S_RADDR, S_RDATA, S_WRITE, S_WRESP, S_DONE} state_t;

  localparam logic [31:0] ADDR_MASK = ~(32'(WSTRB) - 32'd1);

  state_t           state_q, state_d;
  logic [IDWID-1:0] id_q;
  logic [31:0]      addr_q;
  logic [7:0]       len_q;
  logic             write_q;
  logic [8:0]       beat_q, beat_d;
  logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [1:0]       resp_q, resp_d, err_q, err_d;
  logic             accept, last_beat, aw_hs, w_hs;

`ifdef AXI_MASTER_4K_CHECK_EN
  logic [31:0] end_off;
  logic        crosses_4k;
  assign end_off    = {20'd0, cmd_addr[11:0] & ADDR_MASK[11:0]}
                    + ((32'(cmd_len) + 32'd1) * 32'(WSTRB));
  assign crosses_4k = end_off > 32'd4096;
`endif

  assign last_beat = (beat_q == {1'b0, len_q});

  assign arid    = id_q;
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arburst = 2'b01;
  assign awid    = id_q;
  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awburst = 2'b01;
  assign wdata   = wr_data;
  assign wstrb   = wr_strb;
  assign rd_data = rdata;

  // NOTE: every output and next-state value gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    resp_d     = resp_q;
    err_d      = err_q;
    accept     = 1'b0;
    aw_hs      = 1'b0;
    w_hs       = 1'b0;
    cmd_ready  = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    rd_valid   = 1'b0;
    rd_last    = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    wr_ready   = 1'b0;
    wlast      = 1'b0;
    bready     = 1'b0;
    done_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept    = 1'b1;
          beat_d    = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          resp_d    = 2'b00;
          err_d     = 2'b00;
`ifdef AXI_MASTER_4K_CHECK_EN
          if (crosses_4k) begin
            state_d = S_DONE;
            resp_d  = 2'b10;
          end else
`endif
          state_d = cmd_write ? S_WRITE : S_RADDR;
        end
      end
      S_RADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = S_RDATA;
      end
      S_RDATA: begin
        rd_valid = rvalid;
        rready   = rd_ready;
        rd_last  = last_beat;
        if (rvalid && rd_ready) begin
          beat_d = beat_q + 9'd1;
          resp_d = resp_q | rresp;
          if (rid != id_q) err_d[1] = 1'b1;
          if (rlast != last_beat) err_d[0] = 1'b1;
          if (last_beat || rlast) state_d = S_DONE;
        end
      end
      S_WRITE: begin
        // Once the last W beat is sent the local stream is stalled until the next command.
        awvalid  = !aw_done_q;
        wvalid   = wr_valid && !w_done_q;
        wr_ready = wready && !w_done_q;
        wlast    = last_beat;
        aw_hs    = awvalid && awready;
        w_hs     = wvalid && wready;
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs) begin
          beat_d = beat_q + 9'd1;
          if (last_beat) w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) state_d = S_WRESP;
      end
      S_WRESP: begin
        bready = 1'b1;
        if (bvalid) begin
          resp_d = resp_q | bresp;
          if (bid != id_q) err_d[1] = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      write_q    <= 1'b0;
      beat_q     <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      resp_q     <= 2'b00;
      err_q      <= 2'b00;
      done_write <= 1'b0;
      done_id    <= '0;
      done_resp  <= 2'b00;
      done_err   <= 2'b00;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      resp_q    <= resp_d;
      err_q     <= err_d;
      if (accept) begin
        id_q    <= cmd_id;
        addr_q  <= cmd_addr & ADDR_MASK;
        len_q   <= cmd_len;
        write_q <= cmd_write;
      end
      // Completion fields are frozen on entry to DONE and held until the next completion.
      if (state_d == S_DONE && state_q != S_DONE) begin
        done_resp  <= resp_d;
        done_err   <= err_d;
        done_id    <= accept ? cmd_id : id_q;
        done_write <= accept ? cmd_write : write_q;
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed self-checking bench for axi_burst_master (IDWID=4, DWID=64).
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_axi_burst_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [3:0]  cmd_id;
  logic [63:0] wr_data;
  logic [7:0]  wr_strb;
  logic        wr_valid, wr_ready;
  logic [63:0] rd_data;
  logic        rd_last, rd_valid, rd_ready;
  logic        done_valid, done_write;
  logic [3:0]  done_id;
  logic [1:0]  done_resp, done_err;
  logic [3:0]  arid, rid, awid, bid;
  logic [31:0] araddr, awaddr;
  logic [7:0]  arlen, awlen;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [63:0] rdata, wdata;
  logic [7:0]  wstrb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_burst_master #(.IDWID(4), .DWID(64), .WSTRB(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done_valid(done_valid), .done_write(done_write), .done_id(done_id),
    .done_resp(done_resp), .done_err(done_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l; cmd_id = id;
    #1 check("cmd_ready at accept", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_ar(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
    #1;
    check("arvalid after accept", arvalid, 1);
    check("araddr", araddr, a);
    check("arlen", arlen, l);
    check("arburst", arburst, 2'b01);
    check("arid", arid, id);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    #1 check("arvalid dropped", arvalid, 0);
  endtask

  task automatic read_beats(input int len, input int nbeats, input int last_at,
                            input logic [3:0] rid_v, input int bad_beat);
    rd_ready = 1'b1;
    for (int b = 0; b < nbeats; b++) begin
      rvalid = 1'b1;
      rdata  = 64'hA000 + 64'(b);
      rid    = rid_v;
      rresp  = (b == bad_beat) ? 2'b10 : 2'b00;
      rlast  = (b == last_at);
      #1;
      check("rd_valid", rd_valid, 1);
      check("rd_data", rd_data, 64'hA000 + 64'(b));
      check("rd_last", rd_last, (b == len));
      check("rready", rready, 1);
      @(negedge clk);
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rd_ready = 1'b0;
  endtask

  task automatic expect_done(input logic w, input logic [3:0] id, input logic [1:0] resp, input logic [1:0] err);
    #1;
    check("done_valid pulse", done_valid, 1);
    check("done_write", done_write, w);
    check("done_id", done_id, id);
    check("done_resp", done_resp, resp);
    check("done_err", done_err, err);
    check("cmd_ready in DONE", cmd_ready, 0);
    @(negedge clk);
    #1;
    check("done_valid one cycle", done_valid, 0);
    check("cmd_ready back", cmd_ready, 1);
    check("done_resp held", done_resp, resp);
    check("done_err held", done_err, err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    rst_n = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_id = 0;
    wr_data = 0; wr_strb = 0; wr_valid = 0; rd_ready = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    repeat (2) @(negedge clk);
    #1;
    check("reset cmd_ready", cmd_ready, 1);
    check("reset arvalid", arvalid, 0);
    check("reset awvalid", awvalid, 0);
    check("reset wvalid", wvalid, 0);
    check("reset rready", rready, 0);
    check("reset bready", bready, 0);
    check("reset done_valid", done_valid, 0);
    check("reset rd_valid", rd_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Stray responses while idle must not be acknowledged.
    rvalid = 1'b1; bvalid = 1'b1;
    #1;
    check("idle rready", rready, 0);
    check("idle bready", bready, 0);
    check("idle rd_valid", rd_valid, 0);
    @(negedge clk);
    rvalid = 1'b0; bvalid = 1'b0;

    // Read len=3 @0x100, well-formed burst; AR held one extra cycle first.
    send_cmd(1'b0, 32'h100, 8'd3, 4'd5);
    #1 check("ar held before ready", arvalid, 1);
    @(negedge clk);
    do_ar(32'h100, 8'd3, 4'd5);
    read_beats(3, 4, 3, 4'd5, -1);
    expect_done(1'b0, 4'd5, 2'b00, 2'b00);

    // Write len=7 @0x200, all W beats before awready.
    send_cmd(1'b1, 32'h200, 8'd7, 4'd3);
    #1;
    check("awvalid after accept", awvalid, 1);
    check("awaddr", awaddr, 32'h200);
    check("awlen", awlen, 8'd7);
    check("awburst", awburst, 2'b01);
    check("awid", awid, 4'd3);
    wready = 1'b1; wr_strb = 8'hFF;
    for (int b = 0; b < 8; b++) begin
      wr_valid = 1'b1;
      wr_data  = 64'hB000 + 64'(b);
      #1;
      check("wvalid", wvalid, 1);
      check("wr_ready", wr_ready, 1);
      check("wlast", wlast, (b == 7));
      check("wdata", wdata, 64'hB000 + 64'(b));
      check("awvalid pending", awvalid, 1);
      @(negedge clk);
    end
    check("wstrb", wstrb, 8'hFF);
    #1;
    check("wr_ready after last", wr_ready, 0);
    check("wvalid after last", wvalid, 0);
    check("awvalid still held", awvalid, 1);
    wr_valid = 1'b0;
    awready = 1'b1;
    @(negedge clk);
    awready = 1'b0; wready = 1'b0;
    #1;
    check("wresp bready", bready, 1);
    check("wresp awvalid", awvalid, 0);
    bvalid = 1'b1; bid = 4'd3; bresp = 2'b00;
    @(negedge clk);
    bvalid = 1'b0;
    expect_done(1'b1, 4'd3, 2'b00, 2'b00);

    // Write len=0 with AW and the single W beat in the same cycle.
    send_cmd(1'b1, 32'h300, 8'd0, 4'd9);
    awready = 1'b1; wready = 1'b1; wr_valid = 1'b1; wr_data = 64'hC0;
    #1;
    check("len0 wlast", wlast, 1);
    check("len0 awvalid", awvalid, 1);
    check("len0 wvalid", wvalid, 1);
    @(negedge clk);
    awready = 1'b0; wready = 1'b0; wr_valid = 1'b0;
    #1;
    check("len0 bready next cycle", bready, 1);
    check("len0 wvalid in WRESP", wvalid, 0);
    bvalid = 1'b1; bid = 4'd9; bresp = 2'b01;
    @(negedge clk);
    bvalid = 1'b0;
    expect_done(1'b1, 4'd9, 2'b01, 2'b00);

    // Read len=3, slave ends early with rlast on beat 1.
    send_cmd(1'b0, 32'h100, 8'd3, 4'd1);
    do_ar(32'h100, 8'd3, 4'd1);
    read_beats(3, 2, 1, 4'd1, -1);
    expect_done(1'b0, 4'd1, 2'b00, 2'b01);

    // Read len=1 with wrong rid and SLVERR on beat 0; unaligned address is masked.
    send_cmd(1'b0, 32'h30F, 8'd1, 4'd6);
    do_ar(32'h308, 8'd1, 4'd6);
    read_beats(1, 2, 1, 4'd7, 0);
    expect_done(1'b0, 4'd6, 2'b10, 2'b10);

    // Reset asserted during beat 2 of a read.
    send_cmd(1'b0, 32'h400, 8'd3, 4'd2);
    do_ar(32'h400, 8'd3, 4'd2);
    read_beats(3, 2, -1, 4'd2, -1);
    rd_ready = 1'b1; rvalid = 1'b1; rid = 4'd2; rdata = 64'hA002;
    #1 check("beat2 rd_valid before reset", rd_valid, 1);
    rst_n = 1'b0;
    #1;
    check("reset mid-burst rd_valid", rd_valid, 0);
    check("reset mid-burst rready", rready, 0);
    check("reset mid-burst arvalid", arvalid, 0);
    check("reset mid-burst done_valid", done_valid, 0);
    rvalid = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("post-reset no done", done_valid, 0);
      check("post-reset cmd_ready", cmd_ready, 1);
      @(negedge clk);
    end

    // Burst at 0xFF8, len=1 crosses a 4KB page.
    send_cmd(1'b0, 32'hFF8, 8'd1, 4'd4);
`ifdef AXI_MASTER_4K_CHECK_EN
    #1 check("4k no arvalid", arvalid, 0);
    expect_done(1'b0, 4'd4, 2'b10, 2'b00);
`else
    do_ar(32'hFF8, 8'd1, 4'd4);
    read_beats(1, 2, 1, 4'd4, -1);
    expect_done(1'b0, 4'd4, 2'b00, 2'b00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
